// File: rtl/sme_share_codec_pkg.sv
// Shared definitions for the SME masked-datapath boundary codec:
// datapath width, codec FSM states and the Galois LFSR step function.
package sme_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        RSP
    } sme_codec_state_t;

    localparam logic [31:0] SME_LFSR_TAPS = 32'h8020_0003;

    // One Galois step: shift right, fold the taps in when bit 0 falls out.
    function automatic logic [31:0] sme_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? SME_LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/sme_share_codec_lfsr32.sv
// 32-bit Galois LFSR register with load and step controls.
// o_next is the value produced by one step from the effective source
// (the load value when loading, otherwise the current state), i.e. the
// fresh random word available this cycle.
module sme_lfsr32
    import sme_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_step,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    output logic [31:0] o_state,
    output logic [31:0] o_next
);

    logic [31:0] r_state;

    assign o_state = r_state;
    assign o_next  = sme_lfsr_step(i_load ? i_load_data : r_state);

    // Load has priority over stepping; reset returns to the seed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= i_load_data;
        end else if (i_step) begin
            r_state <= sme_lfsr_step(r_state);
        end
    end

endmodule

// File: rtl/sme_share_codec.sv
// Boundary codec between plain words and D-share Boolean masking.
// MASK: one fresh LFSR share per GEN cycle, share 0 closes the XOR.
// UNMASK: XOR of all input shares, answered after a single cycle.
module sme_share_codec
    import sme_pkg::*;
#(
    parameter int unsigned D    = 4,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    output logic                   g_clk_req,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [XLEN-1:0]        req_data,
    input  logic [D-1:0][XLEN-1:0] req_shares,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [XLEN-1:0]        rsp_data,
    output logic [D-1:0][XLEN-1:0] rsp_shares,
    input  logic                   reseed_valid,
    input  logic [XLEN-1:0]        reseed_data
);

    localparam int unsigned    KW     = (D > 1) ? $clog2(D) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(D - 1);

    sme_codec_state_t        r_state;
    logic [KW-1:0]           r_k;
    logic [XLEN-1:0]         r_acc;
    logic                    r_rsp_valid;
    logic [XLEN-1:0]         r_rsp_data;
    logic [D-1:0][XLEN-1:0]  r_rsp_shares;

    logic                    w_reseed;
    logic                    w_gen;
    logic [XLEN-1:0]         w_rand;
    logic [XLEN-1:0]         w_lfsr_state;
    logic [XLEN-1:0]         w_unmask;

    assign w_reseed   = reseed_valid && (reseed_data != '0);
    assign w_gen      = (r_state == GEN);
    assign req_ready  = (r_state == IDLE);
    assign g_clk_req  = (r_state != IDLE) || req_valid;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_shares = r_rsp_shares;

    // A same-cycle reseed replaces the source, so w_rand is step(reseed_data).
    sme_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk       (g_clk),
        .i_rst_n     (g_resetn),
        .i_step      (w_gen),
        .i_load      (w_reseed),
        .i_load_data (reseed_data),
        .o_state     (w_lfsr_state),
        .o_next      (w_rand)
    );

    // Recombine the incoming shares for UNMASK.
    always_comb begin
        w_unmask = '0;
        for (int unsigned i = 0; i < D; i++) begin
            w_unmask = w_unmask ^ req_shares[i];
        end
    end

    // Codec FSM with registered response outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_acc        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_shares <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rsp_shares <= '0;
                        if (req_op) begin
                            r_rsp_data  <= w_unmask;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RSP;
                        end else begin
                            r_rsp_data <= '0;
                            r_acc      <= req_data;
                            r_k        <= KW'(1);
                            if (D == 1) begin
                                r_rsp_shares[0] <= req_data;
                                r_rsp_valid     <= 1'b1;
                                r_state         <= RSP;
                            end else begin
                                r_state <= GEN;
                            end
                        end
                    end
                end
                GEN: begin
                    for (int unsigned i = 1; i < D; i++) begin
                        if (r_k == KW'(i)) begin
                            r_rsp_shares[i] <= w_rand;
                        end
                    end
                    r_acc <= r_acc ^ w_rand;
                    r_k   <= r_k + KW'(1);
                    if (r_k == K_LAST) begin
                        r_rsp_shares[0] <= r_acc ^ w_rand;
                        r_rsp_data      <= '0;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Zero is the LFSR's only fixed point; a nonzero seed and rejected
    // zero reseeds must keep the register out of it.
    a_lfsr_nonzero : assert property (@(posedge g_clk) disable iff (!g_resetn)
        (w_lfsr_state != '0));

endmodule

// File: tb/tb_sme_share_codec.sv
// Randomized self-checking bench for sme_share_codec (D = 4).
module tb_sme_share_codec;

    localparam int unsigned D = 4;

    logic                 g_clk = 1'b0;
    logic                 g_resetn;
    logic                 g_clk_req;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [31:0]          req_data;
    logic [D-1:0][31:0]   req_shares;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic [D-1:0][31:0]   rsp_shares;
    logic                 reseed_valid;
    logic [31:0]          reseed_data;

    int tests = 0;
    int fails = 0;

    sme_share_codec #(
        .D    (D),
        .SEED (32'h0000_0001)
    ) dut (
        .g_clk        (g_clk),
        .g_resetn     (g_resetn),
        .g_clk_req    (g_clk_req),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_shares   (req_shares),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_shares   (rsp_shares),
        .reseed_valid (reseed_valid),
        .reseed_data  (reseed_data)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // ---------------- transaction-level reference model ----------------
    int unsigned m_gen_left;
    int unsigned m_idx;
    bit          m_valid;
    bit          m_is_mask;
    bit          m_was_idle;
    logic [31:0] m_lfsr, m_acc, m_data, m_plain, m_src, m_r;
    logic [31:0] m_sh [D];

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            m_gen_left = 0;
            m_idx      = 0;
            m_valid    = 0;
            m_is_mask  = 0;
            m_lfsr     = 32'h0000_0001;
            m_acc      = 0;
            m_data     = 0;
            m_plain    = 0;
            for (int i = 0; i < D; i++) m_sh[i] = 0;
        end else begin
            m_was_idle = (m_gen_left == 0) && !m_valid;
            if (m_gen_left != 0) begin
                m_src = (reseed_valid && reseed_data != 0) ? reseed_data : m_lfsr;
                m_r   = lfsr_next(m_src);
                m_lfsr = (reseed_valid && reseed_data != 0) ? reseed_data : m_r;
                m_sh[m_idx] = m_r;
                m_acc = m_acc ^ m_r;
                m_idx++;
                m_gen_left--;
                if (m_gen_left == 0) begin
                    m_sh[0] = m_acc;
                    m_valid = 1;
                end
            end else begin
                if (reseed_valid && reseed_data != 0) m_lfsr = reseed_data;
                if (m_valid) begin
                    if (rsp_ready) m_valid = 0;
                end else if (m_was_idle && req_valid) begin
                    for (int i = 0; i < D; i++) m_sh[i] = 0;
                    if (req_op) begin
                        m_data = 0;
                        for (int i = 0; i < D; i++) m_data = m_data ^ req_shares[i];
                        m_is_mask = 0;
                        m_valid   = 1;
                    end else begin
                        m_data     = 0;
                        m_plain    = req_data;
                        m_acc      = req_data;
                        m_idx      = 1;
                        m_is_mask  = 1;
                        m_gen_left = D - 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge g_clk) begin
        logic [31:0] x;
        bit busy;
        if (g_resetn) begin
            busy = (m_gen_left != 0) || m_valid;
            chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            chk("g_clk_req", {31'b0, g_clk_req}, {31'b0, busy || req_valid});
            if (m_valid) begin
                chk("rsp_data", rsp_data, m_data);
                for (int i = 0; i < D; i++) chk($sformatf("rsp_shares[%0d]", i), rsp_shares[i], m_sh[i]);
                if (m_is_mask) begin
                    x = 0;
                    for (int i = 0; i < D; i++) x = x ^ rsp_shares[i];
                    chk("share_xor", x, m_plain);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge g_clk);
        #2;
    endtask

    task automatic reseed(input logic [31:0] v);
        reseed_valid = 1'b1;
        reseed_data  = v;
        cyc();
        reseed_valid = 1'b0;
        reseed_data  = '0;
    endtask

    // Issue one request; optionally reseed when lat == rs_at during the wait.
    task automatic send(input logic op, input logic [31:0] data, input logic [D-1:0][31:0] sh_in,
                        input int rs_at, input logic [31:0] rs_val,
                        output int lat, output logic [D-1:0][31:0] sh, output logic [31:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) bound_fail("req_ready_wait");
        req_valid  = 1'b1;
        req_op     = op;
        req_data   = data;
        req_shares = sh_in;
        cyc();
        req_valid = 1'b0;
        lat = 0;
        forever begin
            if (lat == rs_at) begin
                reseed_valid = 1'b1;
                reseed_data  = rs_val;
            end
            @(negedge g_clk);
            if (rsp_valid) break;
            cyc();
            reseed_valid = 1'b0;
            lat++;
            if (lat > 20) begin
                bound_fail("rsp_valid_wait");
                break;
            end
        end
        reseed_valid = 1'b0;
        sh = rsp_shares;
        d  = rsp_data;
        if (rsp_ready) cyc();
    endtask

    logic [D-1:0][31:0] zsh, sh, held_sh, ush;
    logic [31:0]        d, held_d, x;
    logic [95:0]        seen [$];
    logic [95:0]        trip;
    int                 lat;
    bit                 dup;

    initial begin
        g_resetn     = 1'b0;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        req_data     = '0;
        req_shares   = '0;
        rsp_ready    = 1'b1;
        reseed_valid = 1'b0;
        reseed_data  = '0;
        zsh          = '0;

        #12;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_g_clk_req", {31'b0, g_clk_req}, 32'd0);
        cyc();
        g_resetn = 1'b1;
        cyc();

        // Known sequence from state 1.
        reseed(32'h0000_0001);
        send(1'b0, 32'h0, zsh, -1, 32'h0, lat, sh, d);
        chk("mask0_latency", lat, 32'd3);
        chk("mask0_sh1", sh[1], 32'h8020_0003);
        chk("mask0_sh2", sh[2], 32'hC030_0002);
        chk("mask0_sh3", sh[3], 32'h6018_0001);
        chk("mask0_sh0", sh[0], 32'h2008_0000);
        chk("mask0_data", d, 32'h0);

        // UNMASK fixed vector.
        ush = {32'h8888_8888, 32'h4444_4444, 32'h2222_2222, 32'h1111_1111};
        send(1'b1, 32'h0, ush, -1, 32'h0, lat, sh, d);
        chk("unmask_latency", lat, 32'd0);
        chk("unmask_data", d, 32'hFFFF_FFFF);
        chk("unmask_shares", sh[0] | sh[1] | sh[2] | sh[3], 32'h0);

        // Zero reseed during GEN is ignored: sequence matches state-1 run.
        reseed(32'h0000_0001);
        send(1'b0, 32'h0, zsh, 1, 32'h0, lat, sh, d);
        chk("rs0_sh2", sh[2], 32'hC030_0002);
        chk("rs0_sh0", sh[0], 32'h2008_0000);

        // Reseed to 1 mid-GEN: the share made that cycle is step(1).
        reseed(32'h1234_5677);
        send(1'b0, 32'h0, zsh, 1, 32'h0000_0001, lat, sh, d);
        chk("rs1_sh2", sh[2], 32'h8020_0003);

        // Backpressure: outputs hold, second request waits for handshake.
        rsp_ready = 1'b0;
        send(1'b0, 32'hCAFE_F00D, zsh, -1, 32'h0, lat, held_sh, held_d);
        ush = {32'h0000_00F0, 32'h0000_0F00, 32'h0000_F000, 32'h000F_0000};
        req_valid  = 1'b1;
        req_op     = 1'b1;
        req_shares = ush;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge g_clk);
            chk("hold_sh0", rsp_shares[0], held_sh[0]);
            chk("hold_sh3", rsp_shares[3], held_sh[3]);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        @(negedge g_clk);
        chk("after_hs_valid", {31'b0, rsp_valid}, 32'd0);
        cyc();
        req_valid = 1'b0;
        @(negedge g_clk);
        chk("second_valid", {31'b0, rsp_valid}, 32'd1);
        chk("second_data", rsp_data, 32'h000F_FFF0);
        cyc();

        // Random reseeds + MASK of a fixed word: XOR invariant, unique shares.
        for (int t = 0; t < 100; t++) begin
            reseed($urandom() | 32'h1);
            send(1'b0, 32'hDEAD_BEEF, zsh, -1, 32'h0, lat, sh, d);
            x = sh[0] ^ sh[1] ^ sh[2] ^ sh[3];
            chk("rand_xor", x, 32'hDEAD_BEEF);
            trip = {sh[1], sh[2], sh[3]};
            dup = 0;
            foreach (seen[j]) if (seen[j] == trip) dup = 1;
            chk("rand_unique", {31'b0, dup}, 32'd0);
            seen.push_back(trip);
            if (t % 10 == 0) begin
                for (int i = 0; i < D; i++) ush[i] = $urandom();
                send(1'b1, 32'h0, ush, -1, 32'h0, lat, sh, d);
                chk("rand_unmask", d, ush[0] ^ ush[1] ^ ush[2] ^ ush[3]);
            end
        end

        // Reset during GEN drops the transaction and restores the seed.
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 32'h5555_AAAA;
        cyc();
        req_valid = 1'b0;
        cyc();
        g_resetn = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_shares", rsp_shares[0] | rsp_shares[1] | rsp_shares[2] | rsp_shares[3], 32'd0);
        cyc();
        g_resetn = 1'b1;
        cyc();
        send(1'b0, 32'h0, zsh, -1, 32'h0, lat, sh, d);
        chk("postrst_sh1", sh[1], 32'h8020_0003);
        chk("postrst_sh3", sh[3], 32'h6018_0001);
        chk("postrst_sh0", sh[0], 32'h2008_0000);

        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
